// File: rtl/vga_mem_pkg.sv
// Shared constants and state encoding for the display-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_mem_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // One pending write: {addr, data}
  localparam int ENTRY_W = DEF_ADDR_W + DEF_DATA_W;

  // The state names what the memory port is doing in the current cycle
  typedef enum logic [1:0] {
    S_ACTIVE     = 2'd0,
    S_DRAIN      = 2'd1,
    S_BLANK_IDLE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/display_mem_arbiter_if.sv
// Bundles the VGA read path, the writer handshake and the memory port.
// Latency: n/a (wires only).
// Backpressure: writer holds wr_req until wr_ack; VGA path is never stalled.
interface display_mem_arbiter_if
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              Blank;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  // Arbiter side
  modport slave (
    input  Blank, vga_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output vga_data, wr_ack, mem_addr, mem_wdata, mem_we, fifo_full, fifo_empty
  );

  // Surrounding logic side (sync/pointers, writer, memory)
  modport master (
    output Blank, vga_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  vga_data, wr_ack, mem_addr, mem_wdata, mem_we, fifo_full, fifo_empty
  );

endinterface

// File: rtl/display_mem_arbiter_wr_fifo.sv
// Small synchronous FIFO holding writes that wait for the blanking interval.
// Latency: a push is visible at the head (and in empty) one cycle later.
// Backpressure: push ignored while full, pop ignored while empty; flags registered.
module wr_fifo
  import vga_mem_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = store[rd_ptr];

  // Occupancy after this edge; flags are derived from it so they move with the count
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Entry storage, no reset needed: contents are only read when count says so
  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/display_mem_arbiter.sv
// Shares the display-character memory: VGA reads in active video, queued writes in blanking.
// Latency: mem port registered 1 cycle after inputs; vga_data 2 cycles after the read issue.
// Backpressure: wr_ack withheld while the write FIFO is full; reads are never stalled.
module display_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic                  CLK,
  input logic                  RESET,
  display_mem_arbiter_if.slave bus
);

  localparam int EW = ADDR_W + DATA_W;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              push;
  logic              pop;
  logic              rd_vld;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              we_nxt;

  wr_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RESET),
    .push     (push),
    .push_dat ({bus.wr_addr, bus.wr_data}),
    .pop      (pop),
    .head     (head),
    .full     (bus.fifo_full),
    .empty    (bus.fifo_empty)
  );

  // The cycle right after an ack ignores wr_req, since the writer has not yet
  // had a chance to drop or change it; full is the pre-pop value, so no bypass.
  assign push = bus.wr_req && !bus.wr_ack && !bus.fifo_full;

  // Choose what the port does next: visible video always reads; blanking drains
  // the FIFO one entry per cycle, otherwise keeps reading so pointers can prefetch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    addr_nxt  = bus.vga_addr;
    wdata_nxt = bus.mem_wdata;
    we_nxt    = 1'b0;
    if (!bus.Blank) begin
      state_nxt = S_ACTIVE;
    end else if (!bus.fifo_empty) begin
      state_nxt = S_DRAIN;
    end else begin
      state_nxt = S_BLANK_IDLE;
    end
    if (state_nxt == S_DRAIN) begin
      pop       = 1'b1;
      addr_nxt  = head[EW-1 -: ADDR_W];
      wdata_nxt = head[DATA_W-1:0];
      we_nxt    = 1'b1;
    end
  end

  // State register and registered memory port / handshake outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= S_ACTIVE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.wr_ack    <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.mem_addr  <= addr_nxt;
      bus.mem_wdata <= wdata_nxt;
      bus.mem_we    <= we_nxt;
      bus.wr_ack    <= push;
    end
  end

  // Read return: rd_vld marks that the memory is returning data for a read,
  // so vga_data keeps its last value across write cycles.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_vld       <= 1'b0;
      bus.vga_data <= '0;
    end else begin
      rd_vld <= (state != S_DRAIN);
      if (rd_vld) begin
        bus.vga_data <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_display_mem_arbiter.sv
// Bench for display_mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model of the arbiter.
`timescale 1ns/1ps
module tb_display_mem_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic CLK;
  logic RESET;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_on  = 0;
  int   run;

  display_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  display_mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 3) ? 8'h5A : 8'(i * 17);
  endfunction

  // Single-port display memory with one-cycle synchronous read
  logic [DW-1:0] ram [16];
  bit            ram_ready = 0;
  always @(posedge CLK) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [AW+DW-1:0] q[$];
  logic [AW+DW-1:0] ent;
  logic [DW-1:0]    mm [16];
  bit               mm_ready = 0;
  logic             exp_we = 0, exp_ack = 0, exp_full = 0, exp_empty = 1;
  logic [AW-1:0]    exp_addr = 0;
  logic [DW-1:0]    exp_wdata = 0, exp_vga = 0;
  bit               pend_we = 0;
  logic [AW-1:0]    pend_addr;
  logic [DW-1:0]    pend_dat;
  bit               p1_rd = 0, p2_rd = 0;
  logic [DW-1:0]    p1_val, p2_val;
  bit               do_push;

  always @(posedge CLK or negedge RESET) begin
    if (!mm_ready) begin
      for (int i = 0; i < 16; i++) mm[i] = init_val(i);
      mm_ready = 1;
    end
    if (!RESET) begin
      q.delete();
      exp_we = 0; exp_ack = 0; exp_full = 0; exp_empty = 1;
      exp_addr = 0; exp_wdata = 0; exp_vga = 0;
      pend_we = 0;
      p1_rd = 1; p1_val = mm[0];   // reset port state is a read of address 0
      p2_rd = 0;
    end else begin
      if (pend_we) mm[pend_addr] = pend_dat;
      pend_we = 0;
      if (p2_rd) exp_vga = p2_val;
      p2_rd = p1_rd; p2_val = p1_val;
      do_push = bus.wr_req && !exp_ack && (q.size() < DEPTH);
      if (bus.Blank && q.size() > 0) begin
        ent       = q.pop_front();
        exp_we    = 1;
        exp_addr  = ent[AW+DW-1:DW];
        exp_wdata = ent[DW-1:0];
        pend_we = 1; pend_addr = exp_addr; pend_dat = exp_wdata;
        p1_rd = 0;
      end else begin
        exp_we   = 0;
        exp_addr = bus.vga_addr;
        p1_rd = 1; p1_val = mm[bus.vga_addr];
      end
      if (do_push) q.push_back({bus.wr_addr, bus.wr_data});
      exp_ack   = do_push;
      exp_full  = (q.size() == DEPTH);
      exp_empty = (q.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("mdl_mem_we",     32'(bus.mem_we),     32'(exp_we));
      chk("mdl_mem_addr",   32'(bus.mem_addr),   32'(exp_addr));
      chk("mdl_mem_wdata",  32'(bus.mem_wdata),  32'(exp_wdata));
      chk("mdl_vga_data",   32'(bus.vga_data),   32'(exp_vga));
      chk("mdl_wr_ack",     32'(bus.wr_ack),     32'(exp_ack));
      chk("mdl_fifo_full",  32'(bus.fifo_full),  32'(exp_full));
      chk("mdl_fifo_empty", 32'(bus.fifo_empty), 32'(exp_empty));
    end
  end

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 0;
    bus.wr_req = 1; bus.wr_addr = a; bus.wr_data = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if (bus.wr_ack) got = 1;
    end
    bus.wr_req = 0;
    chk("push_ack_seen", 32'(got), 1);
  endtask

  task automatic new_req();
    bus.wr_req  = 1;
    bus.wr_addr = 4'($urandom);
    bus.wr_data = 8'($urandom);
  endtask

  initial begin
    bit got;
    RESET = 0;
    bus.Blank = 0; bus.vga_addr = 0; bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0;
    repeat (2) @(negedge CLK);
    chk_on = 1;
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_empty",  32'(bus.fifo_empty), 1);
    chk("rst_full",   32'(bus.fifo_full), 0);
    chk("rst_vga",    32'(bus.vga_data), 0);
    RESET = 1;

    // Active read of address 3
    bus.vga_addr = 3;
    @(negedge CLK);
    chk("rd_mem_addr", 32'(bus.mem_addr), 3);
    chk("rd_mem_we",   32'(bus.mem_we), 0);
    repeat (2) @(negedge CLK);
    chk("rd_vga_data", 32'(bus.vga_data), 32'h5A);

    // Deferred write held off until blanking
    push_one(4'd7, 8'h31);
    chk("dw_nonempty", 32'(bus.fifo_empty), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("dw_hold_we", 32'(bus.mem_we), 0);
    end
    bus.Blank = 1;
    @(negedge CLK);
    chk("dw_we",    32'(bus.mem_we), 1);
    chk("dw_addr",  32'(bus.mem_addr), 7);
    chk("dw_wdata", 32'(bus.mem_wdata), 32'h31);
    chk("dw_empty", 32'(bus.fifo_empty), 1);
    @(negedge CLK);
    chk("dw_we_off", 32'(bus.mem_we), 0);
    bus.Blank = 0;
    @(negedge CLK);

    // Full stall: a fifth request waits for the first blank pop
    for (int i = 0; i < 4; i++) push_one(4'(8 + i), 8'(8'hA0 + i));
    chk("full_set", 32'(bus.fifo_full), 1);
    got = 0;
    bus.wr_req = 1; bus.wr_addr = 4'd12; bus.wr_data = 8'hB4;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (bus.wr_ack) got = 1;
    end
    chk("stall_noack", 32'(got), 0);
    bus.Blank = 1;
    @(negedge CLK);
    chk("stall_pop_we",   32'(bus.mem_we), 1);
    chk("stall_pop_addr", 32'(bus.mem_addr), 8);
    chk("stall_ack_lo",   32'(bus.wr_ack), 0);
    chk("stall_full_lo",  32'(bus.fifo_full), 0);
    @(negedge CLK);
    chk("stall_ack_hi", 32'(bus.wr_ack), 1);
    bus.wr_req = 0;
    for (int i = 0; i < 10 && !bus.fifo_empty; i++) @(negedge CLK);
    chk("stall_drained", 32'(bus.fifo_empty), 1);
    bus.Blank = 0;
    repeat (2) @(negedge CLK);

    // Drain interrupted after two blank cycles
    for (int i = 0; i < 4; i++) push_one(4'(4 + i), 8'(8'hC0 + i));
    bus.Blank = 1;
    @(negedge CLK);
    chk("intr_w0_addr", 32'(bus.mem_addr), 4);
    chk("intr_w0_data", 32'(bus.mem_wdata), 32'hC0);
    @(negedge CLK);
    chk("intr_w1_addr", 32'(bus.mem_addr), 5);
    chk("intr_w1_data", 32'(bus.mem_wdata), 32'hC1);
    bus.Blank = 0;
    @(negedge CLK);
    chk("intr_stop_we", 32'(bus.mem_we), 0);
    chk("intr_left",    32'(bus.fifo_empty), 0);
    repeat (4) @(negedge CLK);
    bus.Blank = 1;
    @(negedge CLK);
    chk("intr_w2_addr", 32'(bus.mem_addr), 6);
    chk("intr_w2_data", 32'(bus.mem_wdata), 32'hC2);
    @(negedge CLK);
    chk("intr_w3_addr", 32'(bus.mem_addr), 7);
    chk("intr_w3_data", 32'(bus.mem_wdata), 32'hC3);
    chk("intr_empty",   32'(bus.fifo_empty), 1);
    bus.Blank = 0;
    @(negedge CLK);

    // Same address twice: last one wins
    push_one(4'd2, 8'h10);
    push_one(4'd2, 8'h20);
    bus.Blank = 1;
    @(negedge CLK);
    chk("same_w0", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'h1210);
    @(negedge CLK);
    chk("same_w1", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'h1220);
    bus.Blank = 0; bus.vga_addr = 2;
    repeat (3) @(negedge CLK);
    chk("same_rd", 32'(bus.vga_data), 32'h20);

    // Reset with two entries queued
    push_one(4'd1, 8'h55);
    push_one(4'd9, 8'h66);
    chk("rq_nonempty", 32'(bus.fifo_empty), 0);
    #2 RESET = 0;
    @(negedge CLK);
    chk("rq_we",    32'(bus.mem_we), 0);
    chk("rq_empty", 32'(bus.fifo_empty), 1);
    chk("rq_vga",   32'(bus.vga_data), 0);
    chk("rq_ack",   32'(bus.wr_ack), 0);
    RESET = 1;
    @(negedge CLK);

    // Randomized traffic with irregular blanking intervals
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        bus.Blank = ~bus.Blank;
        run = bus.Blank ? int'($urandom_range(1, 8)) : int'($urandom_range(2, 20));
      end
      run--;
      bus.vga_addr = 4'($urandom);
      if (bus.wr_req && bus.wr_ack) begin
        if ($urandom_range(0, 1) == 1) new_req();
        else bus.wr_req = 0;
      end else if (!bus.wr_req && $urandom_range(0, 3) == 0) begin
        new_req();
      end
      if (c == 1500) begin
        #2 RESET = 0;
        @(negedge CLK);
        RESET = 1;
      end
      @(negedge CLK);
    end
    bus.wr_req = 0;
    repeat (4) @(negedge CLK);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
